// File: rtl/me_pkg.sv
// me_pkg: shared constants and FSM state type for the motion-estimator
// block loader.
//   ME_R_BYTES / ME_R_AW : reference block size and R memory address width
//   ME_S_BYTES / ME_S_AW : search window size and S memory address width
//   ME_PIX_W             : pixel / distortion width
//   ME_MV_W              : motion vector component width
package me_pkg;

  localparam int unsigned ME_R_BYTES = 256;
  localparam int unsigned ME_S_BYTES = 1024;
  localparam int unsigned ME_R_AW    = 8;
  localparam int unsigned ME_S_AW    = 10;
  localparam int unsigned ME_PIX_W   = 8;
  localparam int unsigned ME_MV_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_R,
    LOAD_S,
    RUN,
    CAPTURE,
    REPORT
  } me_state_e;

endpackage

// File: rtl/me_block_loader.sv
// me_block_loader: front-end sequencer for the motion estimator core.
// Streams 256 reference bytes into R memory and 1024 search-window bytes
// into S memory, holds the core start for RUN_CYCLES clocks, captures the
// core result and offers it on a valid/ready handshake.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   go                      one-cycle sequence request (IDLE only)
//   pix_valid/pix_data      input byte stream; pix_ready accepts
//   r_we/r_waddr            R memory write port
//   s_we/s_waddr            S memory write port
//   mem_wdata               write data shared by both memories
//   me_start                level start to the core
//   me_best_dist/me_motion_x/me_motion_y  core result inputs
//   res_valid/res_ready     result handshake; res_dist/res_mv_x/res_mv_y data
//   busy                    high whenever the sequencer is not IDLE
module me_block_loader
  import me_pkg::*;
#(
  parameter int unsigned RUN_CYCLES = 4120
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                go,
  input  logic                pix_valid,
  input  logic [ME_PIX_W-1:0] pix_data,
  output logic                pix_ready,
  output logic                r_we,
  output logic [ME_R_AW-1:0]  r_waddr,
  output logic                s_we,
  output logic [ME_S_AW-1:0]  s_waddr,
  output logic [ME_PIX_W-1:0] mem_wdata,
  output logic                me_start,
  input  logic [ME_PIX_W-1:0] me_best_dist,
  input  logic [ME_MV_W-1:0]  me_motion_x,
  input  logic [ME_MV_W-1:0]  me_motion_y,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ME_PIX_W-1:0] res_dist,
  output logic [ME_MV_W-1:0]  res_mv_x,
  output logic [ME_MV_W-1:0]  res_mv_y,
  output logic                busy
);

  localparam int unsigned RUN_W = 13;

  localparam logic [ME_S_AW-1:0] R_LAST   = ME_S_AW'(ME_R_BYTES - 1);
  localparam logic [ME_S_AW-1:0] S_LAST   = ME_S_AW'(ME_S_BYTES - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(RUN_CYCLES - 1);

  me_state_e             state_q;
  // Shared between LOAD_R and LOAD_S; R addressing uses the low bits.
  logic [ME_S_AW-1:0]    byte_cnt_q;
  logic [RUN_W-1:0]      run_cnt_q;

  logic                  pix_ready_q;
  logic                  r_we_q;
  logic [ME_R_AW-1:0]    r_waddr_q;
  logic                  s_we_q;
  logic [ME_S_AW-1:0]    s_waddr_q;
  logic [ME_PIX_W-1:0]   mem_wdata_q;
  logic                  me_start_q;
  logic                  res_valid_q;
  logic [ME_PIX_W-1:0]   res_dist_q;
  logic [ME_MV_W-1:0]    res_mv_x_q;
  logic [ME_MV_W-1:0]    res_mv_y_q;
  logic                  busy_q;

  logic                  xfer;

  assign xfer = pix_valid && pix_ready_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      run_cnt_q   <= '0;
      pix_ready_q <= 1'b0;
      r_we_q      <= 1'b0;
      r_waddr_q   <= '0;
      s_we_q      <= 1'b0;
      s_waddr_q   <= '0;
      mem_wdata_q <= '0;
      me_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_dist_q  <= '0;
      res_mv_x_q  <= '0;
      res_mv_y_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Write strobes are single-cycle; address and data hold between writes.
      r_we_q <= 1'b0;
      s_we_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q     <= LOAD_R;
            byte_cnt_q  <= '0;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        LOAD_R: begin
          if (xfer) begin
            r_we_q      <= 1'b1;
            r_waddr_q   <= byte_cnt_q[ME_R_AW-1:0];
            mem_wdata_q <= pix_data;
            if (byte_cnt_q == R_LAST) begin
              // pix_ready stays high so the stream continues into S without a bubble.
              state_q    <= LOAD_S;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end

        LOAD_S: begin
          if (xfer) begin
            s_we_q      <= 1'b1;
            s_waddr_q   <= byte_cnt_q;
            mem_wdata_q <= pix_data;
            if (byte_cnt_q == S_LAST) begin
              // The final S write and the first start cycle coincide.
              state_q     <= RUN;
              byte_cnt_q  <= '0;
              pix_ready_q <= 1'b0;
              me_start_q  <= 1'b1;
              run_cnt_q   <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end

        RUN: begin
          if (run_cnt_q == RUN_LAST) begin
            state_q    <= CAPTURE;
            me_start_q <= 1'b0;
            run_cnt_q  <= '0;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end

        CAPTURE: begin
          res_dist_q  <= me_best_dist;
          res_mv_x_q  <= me_motion_x;
          res_mv_y_q  <= me_motion_y;
          res_valid_q <= 1'b1;
          state_q     <= REPORT;
        end

        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          pix_ready_q <= 1'b0;
          me_start_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready = pix_ready_q;
  assign r_we      = r_we_q;
  assign r_waddr   = r_waddr_q;
  assign s_we      = s_we_q;
  assign s_waddr   = s_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign me_start  = me_start_q;
  assign res_valid = res_valid_q;
  assign res_dist  = res_dist_q;
  assign res_mv_x  = res_mv_x_q;
  assign res_mv_y  = res_mv_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_me_block_loader.sv
// Testbench for me_block_loader: directed stimulus, a transaction-level
// reference model compared every cycle, and literal end-point expectations.
module tb_me_block_loader;

  localparam int unsigned RUNC = 4120;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       go = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic [7:0] me_best_dist = 8'h12;
  logic [3:0] me_motion_x = 4'h3;
  logic [3:0] me_motion_y = 4'hD;
  logic       res_ready = 1'b0;

  logic       pix_ready, r_we, s_we, me_start, res_valid, busy;
  logic [7:0] r_waddr, mem_wdata, res_dist;
  logic [9:0] s_waddr;
  logic [3:0] res_mv_x, res_mv_y;

  int checks = 0;
  int errors = 0;

  me_block_loader #(.RUN_CYCLES(RUNC)) dut (
    .clock(clock), .reset_n(reset_n), .go(go),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .r_we(r_we), .r_waddr(r_waddr), .s_we(s_we), .s_waddr(s_waddr),
    .mem_wdata(mem_wdata), .me_start(me_start),
    .me_best_dist(me_best_dist), .me_motion_x(me_motion_x), .me_motion_y(me_motion_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dist(res_dist), .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases of the sequence described by bytes accepted so
  // far and run clocks remaining.
  int         m_phase;   // 0 idle, 1 loading, 2 running, 3 capturing, 4 reporting
  int         m_n;       // bytes accepted in this sequence
  int         m_left;    // start clocks still to go
  logic       e_ready, e_rwe, e_swe, e_start, e_valid, e_busy;
  logic [7:0] e_raddr, e_wdata, e_dist;
  logic [9:0] e_saddr;
  logic [3:0] e_x, e_y;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_n <= 0; m_left <= 0;
      e_ready <= 1'b0; e_rwe <= 1'b0; e_swe <= 1'b0; e_start <= 1'b0;
      e_valid <= 1'b0; e_busy <= 1'b0;
      e_raddr <= '0; e_wdata <= '0; e_dist <= '0; e_saddr <= '0; e_x <= '0; e_y <= '0;
    end else begin
      e_rwe <= 1'b0;
      e_swe <= 1'b0;
      case (m_phase)
        0: if (go) begin
          m_phase <= 1; m_n <= 0; e_ready <= 1'b1; e_busy <= 1'b1;
        end
        1: if (pix_valid) begin
          if (m_n < 256) begin e_rwe <= 1'b1; e_raddr <= 8'(m_n); end
          else begin e_swe <= 1'b1; e_saddr <= 10'(m_n - 256); end
          e_wdata <= pix_data;
          m_n <= m_n + 1;
          if (m_n == 1279) begin
            m_phase <= 2; e_ready <= 1'b0; e_start <= 1'b1; m_left <= RUNC;
          end
        end
        2: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin m_phase <= 3; e_start <= 1'b0; end
        end
        3: begin
          e_dist <= me_best_dist; e_x <= me_motion_x; e_y <= me_motion_y;
          e_valid <= 1'b1; m_phase <= 4;
        end
        4: if (res_ready) begin
          e_valid <= 1'b0; e_busy <= 1'b0; m_phase <= 0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("pix_ready", pix_ready, e_ready);
      check("r_we", r_we, e_rwe);
      check("s_we", s_we, e_swe);
      check("r_waddr", r_waddr, e_raddr);
      check("s_waddr", s_waddr, e_saddr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("me_start", me_start, e_start);
      check("res_valid", res_valid, e_valid);
      check("res_dist", res_dist, e_dist);
      check("res_mv_x", res_mv_x, e_x);
      check("res_mv_y", res_mv_y, e_y);
      check("busy", busy, e_busy);
    end
  end

  // Write and start-pulse observation, grouped by test epoch.
  int epoch = 0;
  int r_ep[256], r_hits[256], s_ep[1024], s_hits[1024];
  int fr_ep = 0, fs_ep = 0;
  logic [7:0] first_r = '0, last_r = '0, last_r_data = '0, last_s_data = '0;
  logic [9:0] first_s = '0, last_s = '0;
  int total_wr = 0;
  int start_len = 0, gap = 0, gap_rec = 0;
  logic start_prev = 1'b0, gap_on = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      start_prev <= 1'b0;
      gap_on     <= 1'b0;
    end else begin
      if (r_we) begin
        r_hits[r_waddr] <= (r_ep[r_waddr] != epoch) ? 1 : r_hits[r_waddr] + 1;
        r_ep[r_waddr]   <= epoch;
        if (fr_ep != epoch) begin fr_ep <= epoch; first_r <= r_waddr; end
        last_r <= r_waddr; last_r_data <= mem_wdata;
      end
      if (s_we) begin
        s_hits[s_waddr] <= (s_ep[s_waddr] != epoch) ? 1 : s_hits[s_waddr] + 1;
        s_ep[s_waddr]   <= epoch;
        if (fs_ep != epoch) begin fs_ep <= epoch; first_s <= s_waddr; end
        last_s <= s_waddr; last_s_data <= mem_wdata;
      end
      if (r_we || s_we) total_wr <= total_wr + 1;
      if (me_start) start_len <= start_prev ? start_len + 1 : 1;
      if (!me_start && start_prev) begin
        if (res_valid) gap_rec <= 1;
        else begin gap <= 1; gap_on <= 1'b1; end
      end else if (gap_on) begin
        gap <= gap + 1;
        if (res_valid) begin gap_rec <= gap + 1; gap_on <= 1'b0; end
      end
      start_prev <= me_start;
    end
  end

  task automatic stream(input int nbytes, input bit toggle, input int go_at, output int cycles);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < nbytes && cyc < 4 * nbytes + 20) begin
      pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      pix_data  = 8'(idx);
      go        = (cyc == go_at);
      @(negedge clock);
      acc = pix_valid && pix_ready;
      @(posedge clock); #1;
      if (acc) idx++;
      cyc++;
    end
    pix_valid = 1'b0;
    go = 1'b0;
    cycles = cyc;
    if (idx < nbytes) check("stream_timeout", idx, nbytes);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!res_valid && n < RUNC + 200) begin
      @(negedge clock);
      n++;
    end
    if (!res_valid) check("res_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  initial begin
    int cyc;
    int wr0;
    int bad;
    int tot;

    epoch = 1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_me_start", me_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // Stream offered while idle must be ignored.
    wr0 = total_wr;
    pix_valid = 1'b1; pix_data = 8'h77;
    repeat (10) begin
      @(posedge clock); #1;
      check("idle_pix_ready", pix_ready, 0);
    end
    pix_valid = 1'b0;
    check("idle_writes", total_wr - wr0, 0);

    // Abort with reset part way into the search window.
    pulse_go();
    stream(556, 1'b0, -1, cyc);
    reset_n = 1'b0;
    #1;
    check("abort_me_start", me_start, 0);
    check("abort_pix_ready", pix_ready, 0);
    check("abort_s_we", s_we, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Full continuous load, with a go during LOAD_R and another during RUN.
    epoch = 2;
    pulse_go();
    stream(1280, 1'b0, 20, cyc);
    check("cont_cycles", cyc, 1280);
    check("cont_ready_after", pix_ready, 0);
    check("cont_start_on", me_start, 1);
    repeat (200) @(posedge clock);
    #1 pulse_go();
    check("run_go_busy", busy, 1);
    check("run_go_start", me_start, 1);
    wait_result();
    check("first_r_epoch", fr_ep, 2);
    check("first_r", first_r, 8'h00);
    check("last_r", last_r, 8'hFF);
    check("last_r_data", last_r_data, 8'hFF);
    check("first_s", first_s, 10'h000);
    check("last_s", last_s, 10'h3FF);
    check("last_s_data", last_s_data, 8'hFF);
    check("start_len", start_len, RUNC);
    check("start_to_valid", gap_rec, 2);
    check("res_dist", res_dist, 8'h12);
    check("res_mv_x", res_mv_x, 4'h3);
    check("res_mv_y", res_mv_y, 4'hD);

    // Result held while the consumer stalls.
    me_best_dist = 8'h99; me_motion_x = 4'h1; me_motion_y = 4'h2;
    repeat (50) begin
      @(posedge clock); #1;
      check("hold_valid", res_valid, 1);
      check("hold_dist", res_dist, 8'h12);
      check("hold_x", res_mv_x, 4'h3);
      check("hold_y", res_mv_y, 4'hD);
    end
    res_ready = 1'b1; go = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0; go = 1'b0;
    check("ack_busy", busy, 0);
    check("ack_valid", res_valid, 0);
    check("ack_go_ignored", pix_ready, 0);
    pulse_go();
    check("rego_ready", pix_ready, 1);
    check("rego_busy", busy, 1);

    // Alternating-valid load.
    epoch = 3;
    me_best_dist = 8'hA5; me_motion_x = 4'hF; me_motion_y = 4'h0;
    stream(1280, 1'b1, -1, cyc);
    check("tog_cycles", cyc, 2559);
    wait_result();
    bad = 0; tot = 0;
    for (int a = 0; a < 256; a++) begin
      if (r_ep[a] != epoch || r_hits[a] != 1) bad++; else tot++;
    end
    for (int a = 0; a < 1024; a++) begin
      if (s_ep[a] != epoch || s_hits[a] != 1) bad++; else tot++;
    end
    check("tog_addr_gaps", bad, 0);
    check("tog_writes", tot, 1280);
    check("tog_res_dist", res_dist, 8'hA5);
    check("tog_res_x", res_mv_x, 4'hF);
    check("tog_res_y", res_mv_y, 4'h0);
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    check("end_busy", busy, 0);
    repeat (3) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
